// File: rtl/decode_stage.sv
// Registered instruction-decode stage: MAIN output entry plus a one-entry skid buffer.
// Fields are decoded combinationally from the raw word held in MAIN.
module decode_stage #(
    parameter int INSTR_W  = 32,
    parameter int OPC_W    = 6,
    parameter int REG_W    = 5,
    parameter int OFF_W    = 16,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [INSTR_W-1:0]       instruction,
    input  logic [ADDR_W-1:0]        pcIn,
    input  logic                     inValid,
    output logic                     inReady,
    output logic [OPC_W-1:0]         opcode,
    output logic [REG_W-1:0]         rsAdd,
    output logic [REG_W-1:0]         rtAdd,
    output logic [REG_W-1:0]         shift,
    output logic [DATA_W-1:0]        immExt,
    output logic [INSTR_W-OPC_W-1:0] label,
    output logic [DATA_W-1:0]        offsetExt,
    output logic [ADDR_W-1:0]        pcOut,
    output logic                     outValid,
    input  logic                     outReady
);

    localparam int IMM_W = INSTR_W - OPC_W - REG_W;

    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  main_pc_q, main_pc_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;
    logic [IMM_W-1:0]   imm_raw;
    logic [OFF_W-1:0]   off_raw;

    assign accept = inValid & in_ready_q;

    always_comb begin
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || outReady) begin
            if (skid_valid_q) begin
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_instr_d = instruction;
                main_pc_d    = pcIn;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // MAIN is stalled: park the incoming word so it is not lost
            skid_instr_d = instruction;
            skid_pc_d    = pcIn;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr_q <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign imm_raw = main_instr_q[IMM_W-1:0];
    assign off_raw = main_instr_q[OFF_W-1:0];

    assign inReady   = in_ready_q;
    assign outValid  = main_valid_q;
    assign pcOut     = main_pc_q;
    assign opcode    = main_instr_q[INSTR_W-1 -: OPC_W];
    assign rsAdd     = main_instr_q[INSTR_W-OPC_W-1 -: REG_W];
    assign rtAdd     = main_instr_q[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign shift     = main_instr_q[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign label     = main_instr_q[INSTR_W-OPC_W-1:0];
    assign immExt    = SIGN_EXT ? DATA_W'($signed(imm_raw)) : DATA_W'(imm_raw);
    assign offsetExt = SIGN_EXT ? DATA_W'($signed(off_raw)) : DATA_W'(off_raw);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a FIFO scoreboard checks both a sign-extending and a
// zero-extending instance every cycle, alongside directed literal checks.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pcIn = '0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;

    logic        s_inReady, s_outValid, z_inReady, z_outValid;
    logic [5:0]  s_opcode, z_opcode;
    logic [4:0]  s_rs, s_rt, s_sh, z_rs, z_rt, z_sh;
    logic [31:0] s_imm, s_off, s_pc, z_imm, z_off, z_pc;
    logic [25:0] s_lbl, z_lbl;

    decode_stage #(.SIGN_EXT(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .flush(flush), .instruction(instruction), .pcIn(pcIn),
        .inValid(inValid), .inReady(s_inReady), .opcode(s_opcode), .rsAdd(s_rs),
        .rtAdd(s_rt), .shift(s_sh), .immExt(s_imm), .label(s_lbl), .offsetExt(s_off),
        .pcOut(s_pc), .outValid(s_outValid), .outReady(outReady)
    );

    decode_stage #(.SIGN_EXT(1'b0)) u_dut_z (
        .clk(clk), .rst(rst), .flush(flush), .instruction(instruction), .pcIn(pcIn),
        .inValid(inValid), .inReady(z_inReady), .opcode(z_opcode), .rsAdd(z_rs),
        .rtAdd(z_rt), .shift(z_sh), .immExt(z_imm), .label(z_lbl), .offsetExt(z_off),
        .pcOut(z_pc), .outValid(z_outValid), .outReady(outReady)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic [25:0] lbl;
        logic [31:0] off;
    } dec_t;

    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    logic [63:0] q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t exp_dec(input logic [31:0] w, input bit sx);
        dec_t d;
        d.opc = 6'(w >> 26);
        d.rs  = 5'((w >> 21) & 32'h1F);
        d.rt  = 5'((w >> 16) & 32'h1F);
        d.lbl = 26'(w & 32'h03FF_FFFF);
        d.imm = w & 32'h001F_FFFF;
        if (sx && w[20]) d.imm = d.imm | 32'hFFE0_0000;
        d.off = w & 32'h0000_FFFF;
        if (sx && w[15]) d.off = d.off | 32'hFFFF_0000;
        return d;
    endfunction

    task automatic chk_dut(input string tag, input bit sx, input logic [63:0] ent,
                           input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] sh, input logic [31:0] imm, input logic [25:0] lbl,
                           input logic [31:0] off, input logic [31:0] pc);
        dec_t e;
        e = exp_dec(ent[31:0], sx);
        chk({tag, ".opcode"}, 64'(opc), 64'(e.opc));
        chk({tag, ".rsAdd"},  64'(rs),  64'(e.rs));
        chk({tag, ".rtAdd"},  64'(rt),  64'(e.rt));
        chk({tag, ".shift"},  64'(sh),  64'(e.rt));
        chk({tag, ".immExt"}, 64'(imm), 64'(e.imm));
        chk({tag, ".label"},  64'(lbl), 64'(e.lbl));
        chk({tag, ".offExt"}, 64'(off), 64'(e.off));
        chk({tag, ".pcOut"},  64'(pc),  64'(ent[63:32]));
    endtask

    // Scoreboard: entries held by the stage, oldest first; front is what must be shown.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("model.s_outValid", 64'(s_outValid), 64'(q.size() > 0));
            chk("model.z_outValid", 64'(z_outValid), 64'(q.size() > 0));
            chk("model.s_inReady",  64'(s_inReady),  64'(q.size() < 2));
            chk("model.z_inReady",  64'(z_inReady),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk_dut("model.s", 1'b1, q[0], s_opcode, s_rs, s_rt, s_sh, s_imm, s_lbl, s_off, s_pc);
                chk_dut("model.z", 1'b0, q[0], z_opcode, z_rs, z_rt, z_sh, z_imm, z_lbl, z_off, z_pc);
            end
            if (flush) begin
                q.delete();
            end else begin
                automatic bit acc  = inValid && (q.size() < 2);
                automatic bit xfer = outReady && (q.size() > 0);
                if (xfer) void'(q.pop_front());
                if (acc) begin
                    q.push_back({pcIn, instruction});
                    n_acc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc);
        instruction = w;
        pcIn        = pc;
        inValid     = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_acc;
        int cyc;

        // reset state
        #1 rst = 1'b1;
        #2;
        chk("rst.s_outValid", 64'(s_outValid), 64'd0);
        chk("rst.s_inReady",  64'(s_inReady),  64'd1);
        chk("rst.s_opcode",   64'(s_opcode),   64'd0);
        chk("rst.s_immExt",   64'(s_imm),      64'd0);
        chk("rst.s_pcOut",    64'(s_pc),       64'd0);
        chk("rst.z_outValid", 64'(z_outValid), 64'd0);
        chk("rst.z_inReady",  64'(z_inReady),  64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // single-word decode, both extension modes
        outReady = 1'b1;
        offer(32'h8C22_8004, 32'h100);
        step();
        chk("w1.opcode",  64'(s_opcode), 64'h23);
        chk("w1.rsAdd",   64'(s_rs),     64'd1);
        chk("w1.rtAdd",   64'(s_rt),     64'd2);
        chk("w1.shift",   64'(s_sh),     64'd2);
        chk("w1.s_imm",   64'(s_imm),    64'h0002_8004);
        chk("w1.z_imm",   64'(z_imm),    64'h0002_8004);
        chk("w1.label",   64'(s_lbl),    64'h022_8004);
        chk("w1.s_off",   64'(s_off),    64'hFFFF_8004);
        chk("w1.z_off",   64'(z_off),    64'h0000_8004);
        chk("w1.pcOut",   64'(s_pc),     64'h100);
        chk("w1.valid",   64'(s_outValid), 64'd1);
        offer(32'h8C32_8004, 32'h104);
        step();
        chk("w2.rtAdd",   64'(s_rt),     64'h12);
        chk("w2.s_imm",   64'(s_imm),    64'hFFF2_8004);
        chk("w2.z_imm",   64'(z_imm),    64'h0012_8004);
        chk("w2.label",   64'(s_lbl),    64'h032_8004);
        chk("w2.pcOut",   64'(z_pc),     64'h104);
        inValid = 1'b0;
        step();
        chk("w2.drained", 64'(s_outValid), 64'd0);

        // backpressure: A held, B to skid, C stalled
        outReady = 1'b0;
        offer(32'h0123_4567, 32'hA00);
        step();
        chk("abc.A_shown",  64'(s_pc), 64'hA00);
        chk("abc.rdy1",     64'(s_inReady), 64'd1);
        offer(32'h89AB_CDEF, 32'hB00);
        step();
        chk("abc.A_held",   64'(s_pc), 64'hA00);
        chk("abc.rdy_drop", 64'(s_inReady), 64'd0);
        offer(32'hFEDC_BA98, 32'hC00);
        step();
        chk("abc.A_held2",  64'(s_pc), 64'hA00);
        chk("abc.A_opc",    64'(s_opcode), 64'h00);
        chk("abc.C_stall",  64'(s_inReady), 64'd0);
        outReady = 1'b1;
        step();
        chk("abc.B_shown",  64'(s_pc), 64'hB00);
        chk("abc.rdy_back", 64'(s_inReady), 64'd1);
        step();
        chk("abc.C_shown",  64'(s_pc), 64'hC00);
        chk("abc.C_opc",    64'(s_opcode), 64'h3F);
        inValid = 1'b0;
        step();
        chk("abc.empty",    64'(s_outValid), 64'd0);

        // flush with both entries full and a word offered
        outReady = 1'b0;
        offer(32'h1111_1111, 32'hE00);
        step();
        offer(32'h2222_2222, 32'hF00);
        step();
        flush = 1'b1;
        offer(32'h3333_3333, 32'h1000);
        step();
        chk("flush2.valid", 64'(s_outValid), 64'd0);
        chk("flush2.ready", 64'(s_inReady), 64'd1);
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        step();
        step();
        chk("flush2.gone",  64'(s_outValid), 64'd0);

        // flush while ready: offered word still discarded
        outReady = 1'b0;
        offer(32'h4444_4444, 32'h1100);
        step();
        flush = 1'b1;
        offer(32'h5555_5555, 32'h1200);
        step();
        chk("flush1.valid", 64'(s_outValid), 64'd0);
        chk("flush1.ready", 64'(s_inReady), 64'd1);
        flush = 1'b0;
        inValid = 1'b0;
        step();
        chk("flush1.gone",  64'(s_outValid), 64'd0);

        // random handshake stream
        start_acc = n_acc;
        cyc = 0;
        while ((n_acc - start_acc) < 10000 && cyc < 60000) begin
            inValid     = ($urandom_range(0, 9) < 7);
            instruction = $urandom;
            pcIn        = $urandom;
            outReady    = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 199) == 0);
            step();
            cyc++;
        end
        chk("random.accepted_10k", 64'((n_acc - start_acc) >= 10000), 64'd1);
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        step();
        step();
        chk("random.drained", 64'(s_outValid), 64'd0);

        // asynchronous reset with both entries full
        outReady = 1'b0;
        offer(32'h6666_6666, 32'h1300);
        step();
        offer(32'h7777_7777, 32'h1400);
        step();
        inValid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.valid",  64'(s_outValid), 64'd0);
        chk("arst.ready",  64'(s_inReady),  64'd1);
        chk("arst.opcode", 64'(s_opcode),   64'd0);
        chk("arst.pcOut",  64'(s_pc),       64'd0);
        chk("arst.label",  64'(s_lbl),      64'd0);
        chk("arst.z_off",  64'(z_off),      64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        outReady = 1'b1;
        offer(32'h8C22_8004, 32'h200);
        step();
        chk("arst.after_opc", 64'(s_opcode), 64'h23);
        chk("arst.after_off", 64'(s_off),    64'hFFFF_8004);
        chk("arst.after_pc",  64'(s_pc),     64'h200);
        inValid = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
